// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
//   Read-only SPI master for a 12-bit MCP3201-style ADC. An internal sample
//   timer (or an on-demand start pulse) launches a 15-SCLK frame: 2 sample
//   window bits, a null bit and D11..D0 MSB first. Good frames update `data`
//   together with a one-cycle `valid` strobe; a frame whose null bit reads 1
//   leaves `data` untouched and sets the sticky `err` flag.
//
//   Output handshake: `valid` is a one-cycle strobe with no back-pressure;
//   `data` is stable from that cycle until the next `valid`.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         enables periodic (timer) sampling
//   start      one-cycle request for an immediate conversion
//   miso       ADC serial data (asynchronous, synchronized internally)
//   cs_n       ADC chip select, active low (flop output)
//   sclk       ADC serial clock, idles low (flop output)
//   data       last good conversion result
//   valid      one-cycle pulse when data updates
//   busy       high from conversion start through the end of the deselect hold
//   err        sticky: a null bit was read as 1
//   dbg_state  current FSM state (0 IDLE, 1 SETUP, 2 SHIFT, 3 DONE, 4 HOLD)
// ---------------------------------------------------------------------------
module adc_spi_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] data,
    output logic        valid,
    output logic        busy,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [TW-1:0]  r_timer;
    logic [8:0]     r_cnt;
    logic [3:0]     r_bit;
    logic [11:0]    r_shift;
    logic           r_null;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_cs_n;
    logic           r_sclk;
    logic [11:0]    r_data;
    logic           r_valid;
    logic           r_busy;
    logic           r_err;

    logic           w_tick;
    logic           w_cnt_last;
    logic           w_hold_last;
    logic           w_sample;

    assign w_tick      = en && (r_timer == TW'(SAMPLE_PERIOD - 1));
    assign w_cnt_last  = (r_cnt == 9'(CLK_DIV - 1));
    // The deselect time is measured from the cs_n rising edge, which happens
    // on entry to DONE, so HOLD itself lasts one cycle less than 2*CLK_DIV.
    assign w_hold_last = (r_cnt == 9'(2 * CLK_DIV - 2));
    // Last clk of an SCLK high phase.
    assign w_sample    = (r_state == S_SHIFT) && w_cnt_last && r_sclk;

    // Sample timer: free-running while enabled, held at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick || start) w_next = S_SETUP;
            S_SETUP: if (w_cnt_last) w_next = S_SHIFT;
            S_SHIFT: if (w_sample && (r_bit == 4'd14)) w_next = S_DONE;
            S_DONE:  w_next = S_HOLD;
            S_HOLD:  if (w_hold_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered pin outputs. cs_n/busy are computed from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_null  <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= miso;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            r_cs_n  <= !((w_next == S_SETUP) || (w_next == S_SHIFT));
            r_busy  <= (w_next != S_IDLE);

            if ((w_next != r_state) || (r_state == S_IDLE) ||
                ((r_state == S_SHIFT) && w_cnt_last)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // SCLK toggles every CLK_DIV cycles in SHIFT only; the frame ends
            // on a high-to-low toggle, so it is low whenever cs_n is high.
            if (r_state == S_SHIFT) begin
                if (w_cnt_last) begin
                    r_sclk <= !r_sclk;
                end
            end else begin
                r_sclk <= 1'b0;
            end

            if (r_state == S_SETUP) begin
                r_bit  <= '0;
                r_null <= 1'b0;
            end

            // Every bit goes through the 12-bit shifter; after 15 bits only
            // D11..D0 remain, so the window and null bits fall off the top.
            if (w_sample) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_shift[10:0], r_sync2};
                if (r_bit == 4'd2) begin
                    r_null <= r_sync2;
                end
            end

            if (r_state == S_DONE) begin
                if (!r_null) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign cs_n      = r_cs_n;
    assign sclk      = r_sclk;
    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
